// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage. Owns the program counter, issues word reads to the
// instruction memory over a request/response handshake, and holds one fetched
// instruction in an output register that the decode stage drains with a
// valid/ready handshake. Branch/jump redirects resolved downstream reload the
// PC and squash whatever fetch is in flight.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   reset          synchronous, active-high reset
//   imem_req       read request valid this cycle (combinational)
//   imem_addr      word address of the request, always equal to the PC
//   imem_ready     memory accepts the request this cycle
//   imem_rvalid    response data valid
//   imem_rdata     response instruction word
//   redirect_valid taken branch/jump, refetch from redirect_pc
//   redirect_pc    redirect target word address
//   if_valid       if_instr / if_pc hold a valid instruction
//   if_instr       fetched instruction
//   if_pc          word address of if_instr
//   if_pc_next     if_pc + 1 (wraps), feeds the branch adder
//   id_ready       decode consumes if_* when if_valid && id_ready
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                ADDR_W   = 5,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_next,
    input  logic              id_ready
);

    // ST_REQ : want to issue a request at pc_reg
    // ST_WAIT: exactly one request outstanding
    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] fetch_pc_reg;   // address of the request in flight
    logic              squash_reg;     // in-flight response must be dropped
    logic              if_valid_reg;
    logic [DATA_W-1:0] if_instr_reg;
    logic [ADDR_W-1:0] if_pc_reg;

    logic slot_free;
    logic accept;
    logic resp;
    logic load;

    // A request only issues when the output slot is (or is about to become)
    // empty, so a live response always has somewhere to land and no
    // overflow/skid path is needed.
    assign slot_free = !if_valid_reg || id_ready;

    // Gated by reset so no request escapes while the PC is being reloaded.
    assign imem_req  = !reset && (state_reg == ST_REQ) && slot_free;
    assign imem_addr = pc_reg;

    assign accept = imem_req && imem_ready;
    // rvalid is only meaningful while a request is outstanding.
    assign resp   = (state_reg == ST_WAIT) && imem_rvalid;
    // A response is loaded only if it belongs to the current instruction
    // stream: not squashed by an earlier redirect and not killed by a
    // redirect arriving in the same cycle.
    assign load   = resp && !squash_reg && !redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_REQ;
            pc_reg       <= RESET_PC;
            fetch_pc_reg <= '0;
            squash_reg   <= 1'b0;
            if_valid_reg <= 1'b0;
            if_instr_reg <= '0;
            if_pc_reg    <= '0;
        end else if (redirect_valid) begin
            // Redirect wins over everything: reload the PC and throw away the
            // instruction currently offered, even if decode takes it now.
            pc_reg       <= redirect_pc;
            if_valid_reg <= 1'b0;
            case (state_reg)
                ST_REQ: begin
                    if (accept) begin
                        // The request just accepted fetches the old path; its
                        // response must be dropped when it comes back.
                        state_reg    <= ST_WAIT;
                        fetch_pc_reg <= pc_reg;
                        squash_reg   <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        // Stale response is arriving right now; just drop it.
                        state_reg  <= ST_REQ;
                        squash_reg <= 1'b0;
                    end else begin
                        squash_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_REQ;
            endcase
        end else begin
            case (state_reg)
                ST_REQ: begin
                    if (accept) begin
                        state_reg    <= ST_WAIT;
                        fetch_pc_reg <= pc_reg;
                        pc_reg       <= pc_reg + ADDR_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state_reg  <= ST_REQ;
                        squash_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_REQ;
            endcase

            if (load) begin
                if_valid_reg <= 1'b1;
                if_instr_reg <= imem_rdata;
                if_pc_reg    <= fetch_pc_reg;
            end else if (if_valid_reg && id_ready) begin
                if_valid_reg <= 1'b0;
            end
        end
    end

    assign if_valid   = if_valid_reg;
    assign if_instr   = if_instr_reg;
    assign if_pc      = if_pc_reg;
    assign if_pc_next = if_pc_reg + ADDR_W'(1);

endmodule
